// File: rtl/logic_unit_pkg.sv
// Shared types and the bitwise operation kernel for the pipelined logic unit.
// The kernel works on a fixed-width word; callers zero-extend and truncate to their WIDTH.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Widest operand the kernel supports; upper bits beyond a caller's WIDTH are discarded.
    localparam int LU_MAX_W = 64;

    typedef logic [LU_MAX_W-1:0] lu_word_t;

    function automatic lu_word_t logic_op(input op_e op, input lu_word_t a, input lu_word_t b);
        lu_word_t y;
        y = a;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = a;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_stage.sv
// Generic one-entry valid/ready register slice. A beat may be loaded in the same
// cycle the held beat drains, so back-to-back slices run at full rate.
module logic_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          vld_q;
    logic [DW-1:0] data_q;

    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;
    assign out_data  = data_q;

    // Data is reset as well so the output ports read zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            vld_q  <= 1'b1;
            data_q <= in_data;
        end else if (out_ready) begin
            vld_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with zero/parity flags and an
// accumulator that can stand in for operand B.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity
);

    localparam int S2_W = WIDTH + 2;

    function automatic logic calc_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic             accept;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] b_eff_p0;
    logic [WIDTH-1:0] y_p0;

    logic             vld_p1;
    logic             rdy_p1;
    logic [WIDTH-1:0] y_p1;
    logic [S2_W-1:0]  data_p1;

    logic             vld_p2;
    logic [S2_W-1:0]  data_p2;

    assign accept = in_valid && in_ready;

    // Stage 0: operand select and logic op; a same-cycle clear forces the accumulated operand to zero.
    always_comb begin
        b_eff_p0 = in_b;
        if (in_acc) begin
            b_eff_p0 = acc_clear ? '0 : acc_q;
        end
    end

    assign y_p0 = WIDTH'(logic_op(op_e'(in_op), lu_word_t'(in_a), lu_word_t'(b_eff_p0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= y_p0;
        end else if (acc_clear) begin
            acc_q <= '0;
        end
    end

    // Stage 1: registered result.
    logic_pipe_stage #(
        .DW(WIDTH)
    ) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (y_p0),
        .out_valid(vld_p1),
        .out_ready(rdy_p1),
        .out_data (y_p1)
    );

    assign data_p1 = {calc_parity(y_p1), calc_zero(y_p1), y_p1};

    // Stage 2: registered result plus flags, driving the output ports directly.
    logic_pipe_stage #(
        .DW(S2_W)
    ) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (vld_p1),
        .in_ready (rdy_p1),
        .in_data  (data_p1),
        .out_valid(vld_p2),
        .out_ready(out_ready),
        .out_data (data_p2)
    );

    assign out_valid  = vld_p2;
    assign out_y      = data_p2[WIDTH-1:0];
    assign out_zero   = data_p2[WIDTH];
    assign out_parity = data_p2[WIDTH+1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized checks of logic_unit_pipe against a queue-based reference model.
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_acc;
    logic             acc_clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_parity;

    logic_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_parity(out_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] y_log[$];
    logic             z_log[$];
    logic             p_log[$];
    int               emit_cyc[$];
    int               acc_cyc[$];
    logic [WIDTH-1:0] m_acc;

    bit               stall_pend;
    logic [WIDTH-1:0] stall_y;
    logic             stall_z;
    logic             stall_p;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input int op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return ~a;
            3:       return ~(a & b);
            4:       return ~(a | b);
            5:       return a ^ b;
            6:       return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // One clock: observe handshakes just before the edge, update the model, advance.
    task automatic tick();
        bit               acc_now;
        bit               emit_now;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] beff;
        #1;
        acc_now  = in_valid && in_ready;
        emit_now = out_valid && out_ready;
        if (stall_pend) begin
            check("stall_valid", out_valid, 1);
            check("stall_y", out_y, stall_y);
            check("stall_zero", out_zero, stall_z);
            check("stall_parity", out_parity, stall_p);
        end
        if (emit_now) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_y", out_y, e);
                check("out_zero", out_zero, (e == 0));
                check("out_parity", out_parity, $countones(e) % 2);
                y_log.push_back(out_y);
                z_log.push_back(out_zero);
                p_log.push_back(out_parity);
                emit_cyc.push_back(cyc);
            end
        end
        stall_pend = out_valid && !out_ready;
        stall_y    = out_y;
        stall_z    = out_zero;
        stall_p    = out_parity;
        if (acc_now) begin
            beff  = in_acc ? (acc_clear ? '0 : m_acc) : in_b;
            e     = ref_op(int'(in_op), in_a, beff);
            m_acc = e;
            exp_q.push_back(e);
            acc_cyc.push_back(cyc);
        end else if (acc_clear) begin
            m_acc = '0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int op, input bit acc, input bit clr, input bit rdy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = 3'(op);
        in_acc    = acc;
        acc_clear = clr;
        out_ready = rdy;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int op,
                        input bit acc, input bit clr);
        int n;
        n = 0;
        drive(1'b1, a, b, op, acc, clr, out_ready);
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        acc_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] sweep_exp [9];
        int base;
        int abase;
        int ebase;
        int start_acc;
        int guard;
        sweep_exp = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0, 8'h01};

        rst_n = 1'b0;
        m_acc = '0;
        stall_pend = 1'b0;
        drive(1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_out_parity", out_parity, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // All eight ops back-to-back, then NOT of FE.
        base  = y_log.size();
        abase = acc_cyc.size();
        ebase = emit_cyc.size();
        for (int op = 0; op < 8; op++) send(8'hF0, 8'h3C, op, 1'b0, 1'b0);
        send(8'hFE, 8'h00, 2, 1'b0, 1'b0);
        idle(4);
        check("sweep_count", y_log.size() - base, 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("sweep_y%0d", i), y_log[base+i], sweep_exp[i]);
            check($sformatf("sweep_zero%0d", i), z_log[base+i], 0);
        end
        for (int i = 0; i < 8; i++) check($sformatf("sweep_par%0d", i), p_log[base+i], 0);
        check("sweep_par_not_fe", p_log[base+8], 1);
        check("latency", emit_cyc[ebase] - acc_cyc[abase], 2);
        check("throughput", emit_cyc[ebase+8] - emit_cyc[ebase], 8);

        // Accumulator chaining.
        base = y_log.size();
        send(8'hF0, 8'h3C, 0, 1'b0, 1'b0);
        send(8'h30, 8'hA5, 5, 1'b1, 1'b0);
        idle(4);
        check("accum_y0", y_log[base], 8'h30);
        check("accum_y1", y_log[base+1], 8'h00);
        check("accum_zero1", z_log[base+1], 1);
        check("accum_par1", p_log[base+1], 0);

        // Clear colliding with an accumulated accept.
        base = y_log.size();
        send(8'hF0, 8'h3C, 0, 1'b0, 1'b0);
        send(8'h0F, 8'hAA, 1, 1'b1, 1'b1);
        send(8'h00, 8'h55, 1, 1'b1, 1'b0);
        idle(4);
        check("clr_y1", y_log[base+1], 8'h0F);
        check("clr_y2", y_log[base+2], 8'h0F);

        // Backpressure: two beats fill the pipe, the third is held off.
        base = y_log.size();
        drive(1'b1, 8'h11, 8'h22, 5, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h33, 8'h0F, 0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h5A, 8'h00, 2, 1'b0, 1'b0, 1'b0);
        #1;
        check("full_in_ready", in_ready, 0);
        repeat (3) tick();
        check("full_in_ready_hold", in_ready, 0);
        out_ready = 1'b1;
        tick();
        idle(4);
        check("bp_count", y_log.size() - base, 3);
        check("bp_y0", y_log[base], 8'h33);
        check("bp_y1", y_log[base+1], 8'h03);
        check("bp_y2", y_log[base+2], 8'hA5);

        // Randomized valid/ready traffic.
        start_acc = acc_cyc.size();
        guard = 0;
        while (acc_cyc.size() - start_acc < 1000 && guard < 20000) begin
            drive($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
                  $urandom_range(0, 7), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
            tick();
            guard++;
        end
        check("rand_accepted", acc_cyc.size() - start_acc, 1000);
        drive(1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b1);
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        check("rand_all_emitted", y_log.size(), acc_cyc.size());
        check("rand_drained_valid", out_valid, 0);

        // Asynchronous reset with both stages holding beats.
        drive(1'b1, 8'hC3, 8'h81, 1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h7E, 8'h18, 6, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_y", out_y, 0);
        check("midrst_out_zero", out_zero, 0);
        check("midrst_out_parity", out_parity, 0);
        exp_q.delete();
        m_acc = '0;
        stall_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(3);
        check("post_rst_no_stale", out_valid, 0);
        base = y_log.size();
        send(8'hFF, 8'h77, 0, 1'b1, 1'b0);
        idle(4);
        check("post_rst_count", y_log.size() - base, 1);
        check("post_rst_acc_y", y_log[base], 8'h00);
        check("post_rst_acc_zero", z_log[base], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
